// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings, default width
// and the single-bit full-subtractor equation.
package serial_subtractor_pkg;

    localparam int SSUB_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        SSUB_IDLE  = 2'd0,
        SSUB_SHIFT = 2'd1,
        SSUB_DONE  = 2'd2
    } ssub_state_e;

    // Returns {borrow_out, difference} for one bit position.
    function automatic logic [1:0] ssub_bit(input logic a, input logic b, input logic bin);
        logic d;
        logic bout;
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
        return {bout, d};
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done operand and result bundle of the serial subtractor.
// With SERIAL_SUB_OVF_EN defined the bundle also carries the signed overflow flag.
interface serial_subtractor_if #(
    parameter int WIDTH = serial_subtractor_pkg::SSUB_DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (output start, a, b, input busy, done, diff, borrow_out, ovf);
    modport slave  (input start, a, b, output busy, done, diff, borrow_out, ovf);
`else
    modport master (output start, a, b, input busy, done, diff, borrow_out);
    modport slave  (input start, a, b, output busy, done, diff, borrow_out);
`endif

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational 1-bit full subtractor cell (a - b - bin), the counterpart of full_adder.
module serial_subtractor_full_subtractor
    import serial_subtractor_pkg::*;
(
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);

    logic [1:0] w_bits;

    assign w_bits = ssub_bit(i_a, i_b, i_bin);
    assign o_d    = w_bits[0];
    assign o_bout = w_bits[1];

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first unsigned subtractor: diff = a - b over WIDTH clocks.
// Optional signed overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = SSUB_DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);

    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    ssub_state_e      r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [CW-1:0]    r_count;
    logic             r_borrow;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic             r_amsb;
    logic             r_bmsb;
    logic             r_ovf;
`endif

    logic w_d;
    logic w_bout;

    serial_subtractor_full_subtractor u_full_subtractor (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_bin  (r_borrow),
        .o_d    (w_d),
        .o_bout (w_bout)
    );

    // Result registers are written only on the final shift so partial sums never leak out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= SSUB_IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_res        <= '0;
            r_count      <= '0;
            r_borrow     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_amsb       <= 1'b0;
            r_bmsb       <= 1'b0;
            r_ovf        <= 1'b0;
`endif
        end else begin
            case (r_state)
                SSUB_IDLE: begin
                    if (bus.start) begin
                        r_a      <= bus.a;
                        r_b      <= bus.b;
                        r_borrow <= 1'b0;
                        r_count  <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= SSUB_SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                        r_amsb   <= bus.a[WIDTH-1];
                        r_bmsb   <= bus.b[WIDTH-1];
`endif
                    end
                end
                SSUB_SHIFT: begin
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_res    <= {w_d, r_res[WIDTH-1:1]};
                    r_borrow <= w_bout;
                    r_count  <= r_count + 1'b1;
                    if (r_count == LAST) begin
                        r_diff       <= {w_d, r_res[WIDTH-1:1]};
                        r_borrow_out <= w_bout;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_state      <= SSUB_DONE;
`ifdef SERIAL_SUB_OVF_EN
                        r_ovf        <= (r_amsb != r_bmsb) && (w_d != r_amsb);
`endif
                    end
                end
                SSUB_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= SSUB_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= SSUB_IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.diff       = r_diff;
    assign bus.borrow_out = r_borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf        = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8); ovf checks appear when
// SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    bit   hold_start = 1'b0;
    exp_t sb[$];

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t       e;
        logic [W:0] full;
        full     = {1'b0, a} - {1'b0, b};
        e.diff   = full[W-1:0];
        e.borrow = full[W];
        e.ovf    = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
        return e;
    endfunction

    // Drives a start request at a falling edge; the next rising edge is the accepting edge.
    task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        @(negedge clk);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        if (push) sb.push_back(model(a, b));
    endtask

    task automatic pop_expected(output exp_t e, output bit ok);
        ok = (sb.size() != 0);
        e  = '0;
        if (ok) e = sb.pop_front();
    endtask

    // Waits (bounded) for done; reports falling edges elapsed, busy edges and diff movement.
    task automatic wait_done(output int cycles, output bit seen, output int busy_cycles,
                             output bit diff_moved);
        logic [W-1:0] d0;
        d0          = bus.diff;
        cycles      = 0;
        seen        = 1'b0;
        busy_cycles = 0;
        diff_moved  = 1'b0;
        while (!seen && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (bus.done) seen = 1'b1;
            else begin
                if (bus.busy) busy_cycles++;
                if (bus.diff !== d0) diff_moved = 1'b1;
            end
            bus.start = hold_start;
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst_n     = 1'b0;
        #12;
        checks++;
        if ({bus.busy, bus.done, bus.borrow_out} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_flags got=%b want=000", {bus.busy, bus.done, bus.borrow_out});
        end
        checks++;
        if (bus.diff !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_diff got=%h want=00", bus.diff);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (bus.ovf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ovf got=%b want=0", bus.ovf);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_after_reset busy=%b done=%b want 0/0", bus.busy, bus.done);
        end
    endtask

    task automatic test_basic();
        int   cyc;
        int   bc;
        bit   seen;
        bit   mv;
        bit   ok;
        exp_t e;
        drive_start(8'h35, 8'h12, 1'b1);
        wait_done(cyc, seen, bc, mv);
        checks++;
        if (!seen || (cyc - 1) != W) begin
            failures++;
            $display("[TB] FAIL basic_latency got=%0d seen=%0b want=%0d", cyc - 1, seen, W);
        end
        checks++;
        if (bc != W) begin
            failures++;
            $display("[TB] FAIL basic_busy_cycles got=%0d want=%0d", bc, W);
        end
        pop_expected(e, ok);
        checks++;
        if (!ok || bus.diff !== e.diff || bus.diff !== 8'h23) begin
            failures++;
            $display("[TB] FAIL basic_diff got=%h want=%h", bus.diff, e.diff);
        end
        checks++;
        if (bus.borrow_out !== e.borrow) begin
            failures++;
            $display("[TB] FAIL basic_borrow got=%b want=%b", bus.borrow_out, e.borrow);
        end
        checks++;
        if (mv) begin
            failures++;
            $display("[TB] FAIL basic_no_partial got=moved want=stable");
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL done_one_cycle got=%b want=0", bus.done);
        end
    endtask

    task automatic test_borrow();
        logic [W-1:0] ops_a [2];
        logic [W-1:0] ops_b [2];
        int   cyc;
        int   bc;
        bit   seen;
        bit   mv;
        bit   ok;
        exp_t e;
        ops_a[0] = 8'h00; ops_b[0] = 8'h01;
        ops_a[1] = 8'h5A; ops_b[1] = 8'h5A;
        for (int k = 0; k < 2; k++) begin
            drive_start(ops_a[k], ops_b[k], 1'b1);
            wait_done(cyc, seen, bc, mv);
            pop_expected(e, ok);
            checks++;
            if (!seen || !ok || bus.diff !== e.diff) begin
                failures++;
                $display("[TB] FAIL borrow_diff_%0d got=%h want=%h seen=%0b", k, bus.diff, e.diff, seen);
            end
            checks++;
            if (bus.borrow_out !== e.borrow) begin
                failures++;
                $display("[TB] FAIL borrow_flag_%0d got=%b want=%b", k, bus.borrow_out, e.borrow);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int   dones;
        bit   ok;
        exp_t e;
        dones = 0;
        e     = '0;
        drive_start(8'h10, 8'h01, 1'b1);
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (bus.done) begin
                dones++;
                if (dones == 1) begin
                    pop_expected(e, ok);
                    checks++;
                    if (!ok || bus.diff !== e.diff || bus.borrow_out !== e.borrow) begin
                        failures++;
                        $display("[TB] FAIL busy_ignore_diff got=%h/%b want=%h/%b",
                                 bus.diff, bus.borrow_out, e.diff, e.borrow);
                    end
                end
            end
            bus.start = (c == 3);
            if (c == 3) begin
                bus.a = 8'hFF;
                bus.b = 8'h00;
            end
        end
        checks++;
        if (dones != 1) begin
            failures++;
            $display("[TB] FAIL busy_ignore_dones got=%0d want=1", dones);
        end
        checks++;
        if (bus.diff !== 8'h0F) begin
            failures++;
            $display("[TB] FAIL busy_ignore_final got=%h want=0f", bus.diff);
        end
    endtask

    task automatic test_reset_mid_op();
        int   dones;
        int   cyc;
        int   bc;
        bit   seen;
        bit   mv;
        bit   ok;
        exp_t e;
        drive_start(8'h77, 8'h11, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midreset_busy_before got=%b want=1", bus.busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.borrow_out} !== 3'b000 || bus.diff !== 8'h00) begin
            failures++;
            $display("[TB] FAIL midreset_outputs got=%b/%h want=000/00",
                     {bus.busy, bus.done, bus.borrow_out}, bus.diff);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("[TB] FAIL midreset_no_done got=%0d want=0", dones);
        end
        drive_start(8'h09, 8'h03, 1'b1);
        wait_done(cyc, seen, bc, mv);
        pop_expected(e, ok);
        checks++;
        if (!seen || !ok || bus.diff !== e.diff || bus.diff !== 8'h06) begin
            failures++;
            $display("[TB] FAIL midreset_rerun got=%h want=%h seen=%0b", bus.diff, e.diff, seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ops_a [4];
        logic [W-1:0] ops_b [4];
        int   cyc;
        int   bc;
        bit   seen;
        bit   mv;
        bit   ok;
        exp_t e;
        ops_a[0] = 8'h35; ops_b[0] = 8'h12;
        ops_a[1] = 8'h00; ops_b[1] = 8'h01;
        ops_a[2] = 8'hC8; ops_b[2] = 8'h64;
        ops_a[3] = 8'h01; ops_b[3] = 8'h80;
        hold_start = 1'b1;
        drive_start(ops_a[0], ops_b[0], 1'b1);
        for (int k = 0; k < 4; k++) begin
            wait_done(cyc, seen, bc, mv);
            if (k > 0) begin
                checks++;
                if (!seen || cyc != W + 2) begin
                    failures++;
                    $display("[TB] FAIL b2b_period_%0d got=%0d want=%0d seen=%0b", k, cyc, W + 2, seen);
                end
                checks++;
                if (mv) begin
                    failures++;
                    $display("[TB] FAIL b2b_stable_%0d got=moved want=stable", k);
                end
            end
            pop_expected(e, ok);
            checks++;
            if (!seen || !ok || bus.diff !== e.diff || bus.borrow_out !== e.borrow) begin
                failures++;
                $display("[TB] FAIL b2b_result_%0d got=%h/%b want=%h/%b",
                         k, bus.diff, bus.borrow_out, e.diff, e.borrow);
            end
            if (k < 3) begin
                bus.a = ops_a[k+1];
                bus.b = ops_b[k+1];
                sb.push_back(model(ops_a[k+1], ops_b[k+1]));
            end else begin
                hold_start = 1'b0;
                bus.start  = 1'b0;
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_stop got=%b want=0", bus.busy);
        end
    endtask

`ifdef SERIAL_SUB_OVF_EN
    task automatic test_ovf();
        logic [W-1:0] ops_a [3];
        logic [W-1:0] ops_b [3];
        int   cyc;
        int   bc;
        bit   seen;
        bit   mv;
        bit   ok;
        exp_t e;
        ops_a[0] = 8'h80; ops_b[0] = 8'h01;
        ops_a[1] = 8'h7F; ops_b[1] = 8'hFF;
        ops_a[2] = 8'h05; ops_b[2] = 8'h03;
        for (int k = 0; k < 3; k++) begin
            drive_start(ops_a[k], ops_b[k], 1'b1);
            wait_done(cyc, seen, bc, mv);
            pop_expected(e, ok);
            checks++;
            if (!seen || !ok || bus.ovf !== e.ovf) begin
                failures++;
                $display("[TB] FAIL ovf_flag_%0d got=%b want=%b", k, bus.ovf, e.ovf);
            end
            checks++;
            if (bus.diff !== e.diff || bus.borrow_out !== e.borrow) begin
                failures++;
                $display("[TB] FAIL ovf_result_%0d got=%h/%b want=%h/%b",
                         k, bus.diff, bus.borrow_out, e.diff, e.borrow);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_start_while_busy();
        test_reset_mid_op();
        test_back_to_back();
`ifdef SERIAL_SUB_OVF_EN
        test_ovf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
